// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard and stall controller:
// FSM states, control bundle widths and bit positions within each bundle.
package hdu_pkg;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_LU  = 2'd1,
    S_MW  = 2'd2
  } hdu_state_e;

  localparam int REG_W = 5;
  localparam int M_W   = 3;
  localparam int EX_W  = 3;
  localparam int WB_W  = 2;

  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int EX_REGDST   = 2;
  localparam int EX_ALUOP    = 1;
  localparam int EX_ALUSRC   = 0;

  localparam int LU_CNT_W = 3;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard/stall
// controller (slave). No handshake: every output is a same-cycle function of state and inputs.
interface hazard_stall_ctrl_if import hdu_pkg::*; #(
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] rs_ID_IN;
  logic [REG_W-1:0] rt_ID_IN;
  logic [REG_W-1:0] rt_EX_IN;
  logic             MemRead_EX_IN;
  logic             MemAcc_MEM_IN;
  logic             mem_ready_IN;
  logic             branch_taken_IN;
  logic [M_W-1:0]   M_IN;
  logic [EX_W-1:0]  EX_IN;
  logic [WB_W-1:0]  WB_IN;

  logic [M_W-1:0]   M_HDU;
  logic [EX_W-1:0]  EX_HDU;
  logic [WB_W-1:0]  WB_HDU;
  logic             PCWrite_HDU;
  logic             IFIDWrite_HDU;
  logic             IDEXWrite_HDU;
  logic             EXMEMWrite_HDU;
  logic             flush_IFID_HDU;
  logic             flush_IDEX_HDU;
  logic             flush_EXMEM_HDU;
  logic [CNT_W-1:0] stall_cnt_HDU;
  logic [CNT_W-1:0] flush_cnt_HDU;
  hdu_state_e       state_dbg;

  modport master (
    output rs_ID_IN, rt_ID_IN, rt_EX_IN, MemRead_EX_IN, MemAcc_MEM_IN,
           mem_ready_IN, branch_taken_IN, M_IN, EX_IN, WB_IN,
    input  M_HDU, EX_HDU, WB_HDU, PCWrite_HDU, IFIDWrite_HDU, IDEXWrite_HDU,
           EXMEMWrite_HDU, flush_IFID_HDU, flush_IDEX_HDU, flush_EXMEM_HDU,
           stall_cnt_HDU, flush_cnt_HDU, state_dbg
  );

  modport slave (
    input  rs_ID_IN, rt_ID_IN, rt_EX_IN, MemRead_EX_IN, MemAcc_MEM_IN,
           mem_ready_IN, branch_taken_IN, M_IN, EX_IN, WB_IN,
    output M_HDU, EX_HDU, WB_HDU, PCWrite_HDU, IFIDWrite_HDU, IDEXWrite_HDU,
           EXMEMWrite_HDU, flush_IFID_HDU, flush_IDEX_HDU, flush_EXMEM_HDU,
           stall_cnt_HDU, flush_cnt_HDU, state_dbg
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc_i high, sticks at all-ones.
module hdu_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-wait stall and taken-branch flush sequencing for the
// ID/EX buffer, with saturating stall and flush debug counters.
module hazard_stall_ctrl import hdu_pkg::*; #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input logic                clk_HDU,
  input logic                rst_n_HDU,
  hazard_stall_ctrl_if.slave hdu
);

  localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LU_STALL_CYCLES - 1);

  hdu_state_e          state_q, state_d;
  logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic                lu_hz, mw, lu_active;
  logic                pc_we, ifid_we, idex_we, exmem_we;
  logic                flush, bubble;

  assign mw    = hdu.MemAcc_MEM_IN & ~hdu.mem_ready_IN;
  assign lu_hz = hdu.MemRead_EX_IN & (hdu.rt_EX_IN != '0) &
                 ((hdu.rt_EX_IN == hdu.rs_ID_IN) | (hdu.rt_EX_IN == hdu.rt_ID_IN));
  // Bubbles still owed, either in S_LU or parked in S_MW by a memory wait.
  assign lu_active = (state_q != S_RUN) & (lu_cnt_q != '0);

  always_ff @(posedge clk_HDU or negedge rst_n_HDU) begin
    if (!rst_n_HDU) begin
      state_q  <= S_RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    idex_we  = 1'b1;
    exmem_we = 1'b1;
    flush    = 1'b0;
    bubble   = 1'b0;
    // An outstanding memory op freezes everything, including a pending branch flush.
    if (mw) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      state_d  = S_MW;
      if (state_q == S_LU) lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
    end else if (hdu.branch_taken_IN) begin
      flush    = 1'b1;
      bubble   = 1'b1;
      state_d  = S_RUN;
      lu_cnt_d = '0;
    end else if (lu_active) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      bubble   = 1'b1;
      lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
      state_d  = (lu_cnt_q == LU_CNT_W'(1)) ? S_RUN : S_LU;
    end else if (lu_hz) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        state_d  = S_LU;
        lu_cnt_d = LU_RELOAD;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      state_d = S_RUN;
    end
    if (!rst_n_HDU) begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      flush    = 1'b0;
      bubble   = 1'b0;
    end
  end

  assign hdu.PCWrite_HDU     = pc_we;
  assign hdu.IFIDWrite_HDU   = ifid_we;
  assign hdu.IDEXWrite_HDU   = idex_we;
  assign hdu.EXMEMWrite_HDU  = exmem_we;
  assign hdu.flush_IFID_HDU  = flush;
  assign hdu.flush_IDEX_HDU  = flush;
  assign hdu.flush_EXMEM_HDU = flush;
  assign hdu.M_HDU           = bubble ? '0 : hdu.M_IN;
  assign hdu.EX_HDU          = bubble ? '0 : hdu.EX_IN;
  assign hdu.WB_HDU          = bubble ? '0 : hdu.WB_IN;
  assign hdu.state_dbg       = state_q;

  hdu_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_HDU),
    .rst_ni (rst_n_HDU),
    .inc_i  (~pc_we),
    .cnt_o  (hdu.stall_cnt_HDU)
  );

  hdu_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_HDU),
    .rst_ni (rst_n_HDU),
    .inc_i  (flush),
    .cnt_o  (hdu.flush_cnt_HDU)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (1-cycle/16-bit and 3-cycle/4-bit)
// share stimulus and are checked cycle by cycle against a pipeline-level model.
module tb_hazard_stall_ctrl;
  import hdu_pkg::*;

  localparam int K_RUN = 0, K_WAIT = 1, K_BUB = 2, K_FLUSH = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [4:0] rs, rt, rt_ex;
  logic       memread, memacc, ready, br;
  logic [2:0] m_in, ex_in;
  logic [1:0] wb_in;

  hazard_stall_ctrl_if #(.CNT_W(16)) if_a ();
  hazard_stall_ctrl_if #(.CNT_W(4))  if_b ();

  assign if_a.rs_ID_IN = rs;        assign if_b.rs_ID_IN = rs;
  assign if_a.rt_ID_IN = rt;        assign if_b.rt_ID_IN = rt;
  assign if_a.rt_EX_IN = rt_ex;     assign if_b.rt_EX_IN = rt_ex;
  assign if_a.MemRead_EX_IN = memread; assign if_b.MemRead_EX_IN = memread;
  assign if_a.MemAcc_MEM_IN = memacc;  assign if_b.MemAcc_MEM_IN = memacc;
  assign if_a.mem_ready_IN = ready;    assign if_b.mem_ready_IN = ready;
  assign if_a.branch_taken_IN = br;    assign if_b.branch_taken_IN = br;
  assign if_a.M_IN = m_in;   assign if_b.M_IN = m_in;
  assign if_a.EX_IN = ex_in; assign if_b.EX_IN = ex_in;
  assign if_a.WB_IN = wb_in; assign if_b.WB_IN = wb_in;

  hazard_stall_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk_HDU(clk), .rst_n_HDU(rst_n), .hdu(if_a.slave));
  hazard_stall_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(4)) dut_b (
    .clk_HDU(clk), .rst_n_HDU(rst_n), .hdu(if_b.slave));

  // Observed outputs: {PC,IFID,IDEX,EXMEM, flushIF,flushID,flushEX, M,EX,WB}
  logic [14:0] got_o [2];
  logic [15:0] got_s [2];
  logic [15:0] got_f [2];
  assign got_o[0] = {if_a.PCWrite_HDU, if_a.IFIDWrite_HDU, if_a.IDEXWrite_HDU, if_a.EXMEMWrite_HDU,
                     if_a.flush_IFID_HDU, if_a.flush_IDEX_HDU, if_a.flush_EXMEM_HDU,
                     if_a.M_HDU, if_a.EX_HDU, if_a.WB_HDU};
  assign got_o[1] = {if_b.PCWrite_HDU, if_b.IFIDWrite_HDU, if_b.IDEXWrite_HDU, if_b.EXMEMWrite_HDU,
                     if_b.flush_IFID_HDU, if_b.flush_IDEX_HDU, if_b.flush_EXMEM_HDU,
                     if_b.M_HDU, if_b.EX_HDU, if_b.WB_HDU};
  assign got_s[0] = if_a.stall_cnt_HDU;
  assign got_f[0] = if_a.flush_cnt_HDU;
  assign got_s[1] = {12'd0, if_b.stall_cnt_HDU};
  assign got_f[1] = {12'd0, if_b.flush_cnt_HDU};

  // Reference model: bubbles still owed, whether the last cycle was a memory wait, counters.
  int bub [2];
  bit wt [2];
  int sc [2];
  int fc [2];
  int kind [2];
  int lu_p [2];
  int cmax [2];
  logic [14:0] exp_o [2];
  logic [15:0] exp_s [2];
  logic [15:0] exp_f [2];
  int total, bad;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      bub[d] = 0; wt[d] = 1'b0; sc[d] = 0; fc[d] = 0;
    end
  endtask

  task automatic drive(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_rtex,
                       input logic a_mr, input logic a_ma, input logic a_rdy, input logic a_br);
    rs = a_rs; rt = a_rt; rt_ex = a_rtex;
    memread = a_mr; memacc = a_ma; ready = a_rdy; br = a_br;
    m_in = 3'($urandom); ex_in = 3'($urandom); wb_in = 2'($urandom);
  endtask

  task automatic eval();
    logic mw_b, hz_b;
    logic [7:0] pass;
    mw_b = memacc & ~ready;
    hz_b = memread && (rt_ex != 5'd0) && (rt_ex == rs || rt_ex == rt);
    pass = {m_in, ex_in, wb_in};
    for (int d = 0; d < 2; d++) begin
      if (!rst_n)                  kind[d] = K_RUN;
      else if (mw_b)               kind[d] = K_WAIT;
      else if (br)                 kind[d] = K_FLUSH;
      else if (bub[d] > 0 || hz_b) kind[d] = K_BUB;
      else                         kind[d] = K_RUN;
      case (kind[d])
        K_WAIT:  exp_o[d] = {4'b0000, 3'b000, pass};
        K_FLUSH: exp_o[d] = {4'b1111, 3'b111, 8'h00};
        K_BUB:   exp_o[d] = {4'b0011, 3'b000, 8'h00};
        default: exp_o[d] = {4'b1111, 3'b000, pass};
      endcase
      exp_s[d] = 16'(sc[d]);
      exp_f[d] = 16'(fc[d]);
    end
  endtask

  task automatic advance();
    for (int d = 0; d < 2; d++) begin
      if (rst_n) begin
        case (kind[d])
          K_WAIT: begin
            if (!wt[d] && bub[d] > 0) bub[d]--;
            wt[d] = 1'b1;
          end
          K_FLUSH: begin bub[d] = 0; wt[d] = 1'b0; end
          K_BUB: begin
            if (bub[d] > 0) bub[d]--;
            else bub[d] = lu_p[d] - 1;
            wt[d] = 1'b0;
          end
          default: wt[d] = 1'b0;
        endcase
        if ((kind[d] == K_WAIT || kind[d] == K_BUB) && sc[d] < cmax[d]) sc[d]++;
        if (kind[d] == K_FLUSH && fc[d] < cmax[d]) fc[d]++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    drive(5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
    #2; eval();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({got_o[d], got_s[d], got_f[d]} !== {exp_o[d], exp_s[d], exp_f[d]}) begin
        bad++;
        $display("FAIL reset dut%0d: got out=%h s=%0d f=%0d want out=%h s=%0d f=%0d",
                 d, got_o[d], got_s[d], got_f[d], exp_o[d], exp_s[d], exp_f[d]);
      end
    end
    total++;
    if (if_a.state_dbg !== S_RUN || if_b.state_dbg !== S_RUN) begin
      bad++;
      $display("FAIL reset_state: got a=%0d b=%0d want %0d", if_a.state_dbg, if_b.state_dbg, S_RUN);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(5'd5, 5'd9, 5'd5, (c == 0), 1'b0, 1'b1, 1'b0);
      if (c == 0) m_in = 3'b010;
      #2; eval();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({got_o[d], got_s[d], got_f[d]} !== {exp_o[d], exp_s[d], exp_f[d]}) begin
          bad++;
          $display("FAIL load_use c%0d dut%0d: got out=%h s=%0d f=%0d want out=%h s=%0d f=%0d",
                   c, d, got_o[d], got_s[d], got_f[d], exp_o[d], exp_s[d], exp_f[d]);
        end
      end
      total++;
      if (c == 0 && (got_o[0][14:13] !== 2'b00 || got_o[0][7:0] !== 8'h00)) begin
        bad++;
        $display("FAIL load_use_bubble: got out=%h want PC/IFID=0 bundles=0", got_o[0]);
      end else if (c == 1 && (got_s[0] !== 16'd1 || got_o[0][14:11] !== 4'hf)) begin
        bad++;
        $display("FAIL load_use_resume: got stall=%0d en=%h want 1 and f", got_s[0], got_o[0][14:11]);
      end
      advance();
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2; eval();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (got_o[d] !== {4'hf, 3'b000, m_in, ex_in, wb_in} || got_o[d] !== exp_o[d]) begin
        bad++;
        $display("FAIL zero_reg dut%0d: got out=%h want %h", d, got_o[d], exp_o[d]);
      end
    end
    advance();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom), 1'b0, 1'b1, (c == 3), 1'b0);
      #2; eval();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({got_o[d], got_s[d], got_f[d]} !== {exp_o[d], exp_s[d], exp_f[d]}) begin
          bad++;
          $display("FAIL mem_wait c%0d dut%0d: got out=%h s=%0d f=%0d want out=%h s=%0d f=%0d",
                   c, d, got_o[d], got_s[d], got_f[d], exp_o[d], exp_s[d], exp_f[d]);
        end
      end
      total++;
      if (c < 3 && got_o[0][14:11] !== 4'h0) begin
        bad++;
        $display("FAIL mem_wait_freeze c%0d: got en=%h want 0", c, got_o[0][14:11]);
      end else if (c == 3 && (got_o[0][14:11] !== 4'hf || got_s[0] !== 16'd3)) begin
        bad++;
        $display("FAIL mem_wait_resume: got en=%h stall=%0d want f and 3", got_o[0][14:11], got_s[0]);
      end
      advance();
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
      else        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2; eval();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({got_o[d], got_s[d], got_f[d]} !== {exp_o[d], exp_s[d], exp_f[d]}) begin
          bad++;
          $display("FAIL branch_lu c%0d dut%0d: got out=%h s=%0d f=%0d want out=%h s=%0d f=%0d",
                   c, d, got_o[d], got_s[d], got_f[d], exp_o[d], exp_s[d], exp_f[d]);
        end
      end
      total++;
      if (c == 0 && got_o[0][14:8] !== 7'h7f) begin
        bad++;
        $display("FAIL branch_flush: got en/flush=%h want 7f", got_o[0][14:8]);
      end else if (c == 1 && (got_f[0] !== 16'd1 || got_s[0] !== 16'd0)) begin
        bad++;
        $display("FAIL branch_counts: got flush=%0d stall=%0d want 1 and 0", got_f[0], got_s[0]);
      end
      advance();
    end
  endtask

  // Three-cycle variant: plain 3-bubble run, then a hazard interrupted by a 2-cycle memory wait.
  task automatic test_lu3(input bit with_mw);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(5'd6, 5'd2, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      else if (with_mw && (c == 1 || c == 2)) drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      else drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #2; eval();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({got_o[d], got_s[d], got_f[d]} !== {exp_o[d], exp_s[d], exp_f[d]}) begin
          bad++;
          $display("FAIL lu3 mw=%0d c%0d dut%0d: got out=%h s=%0d f=%0d want out=%h s=%0d f=%0d",
                   with_mw, c, d, got_o[d], got_s[d], got_f[d], exp_o[d], exp_s[d], exp_f[d]);
        end
      end
      if (c == 3) begin
        total++;
        if (got_o[1][14:11] !== (with_mw ? 4'b0011 : 4'b1111)) begin
          bad++;
          $display("FAIL lu3_tail mw=%0d: got en=%h", with_mw, got_o[1][14:11]);
        end
      end
      if (c == 2 && with_mw) begin
        total++;
        if (if_b.state_dbg !== S_MW) begin
          bad++;
          $display("FAIL lu3_state: got %0d want %0d", if_b.state_dbg, S_MW);
        end
      end
      if (c == 4) begin
        total++;
        if (got_o[1][14:11] !== 4'hf || got_s[1] !== (with_mw ? 16'd4 : 16'd3)) begin
          bad++;
          $display("FAIL lu3_done mw=%0d: got en=%h stall=%0d", with_mw, got_o[1][14:11], got_s[1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 21; c++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom), 1'b0, 1'b1, (c == 20), 1'b0);
      #2; eval();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({got_o[d], got_s[d], got_f[d]} !== {exp_o[d], exp_s[d], exp_f[d]}) begin
          bad++;
          $display("FAIL saturation c%0d dut%0d: got out=%h s=%0d f=%0d want out=%h s=%0d f=%0d",
                   c, d, got_o[d], got_s[d], got_f[d], exp_o[d], exp_s[d], exp_f[d]);
        end
      end
      advance();
    end
    total++;
    if (got_s[1] !== 16'd15 || got_s[0] !== 16'd20) begin
      bad++;
      $display("FAIL saturation_final: got b=%0d a=%0d want 15 and 20", got_s[1], got_s[0]);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    #2; eval(); advance();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2; rst_n = 1'b0; #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (got_o[d] !== {4'hf, 3'b000, m_in, ex_in, wb_in} || got_s[d] !== 16'd0 || got_f[d] !== 16'd0) begin
        bad++;
        $display("FAIL reset_mid dut%0d: got out=%h s=%0d f=%0d", d, got_o[d], got_s[d], got_f[d]);
      end
    end
    total++;
    if (if_b.state_dbg !== S_RUN) begin
      bad++;
      $display("FAIL reset_mid_state: got %0d want %0d", if_b.state_dbg, S_RUN);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2; eval();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({got_o[d], got_s[d], got_f[d]} !== {exp_o[d], exp_s[d], exp_f[d]}) begin
        bad++;
        $display("FAIL reset_mid_run dut%0d: got out=%h s=%0d f=%0d want out=%h s=%0d f=%0d",
                 d, got_o[d], got_s[d], got_f[d], exp_o[d], exp_s[d], exp_f[d]);
      end
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0));
      #2; eval();
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({got_o[d], got_s[d], got_f[d]} !== {exp_o[d], exp_s[d], exp_f[d]}) begin
          bad++;
          $display("FAIL random c%0d dut%0d: got out=%h s=%0d f=%0d want out=%h s=%0d f=%0d",
                   c, d, got_o[d], got_s[d], got_f[d], exp_o[d], exp_s[d], exp_f[d]);
        end
      end
      advance();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    lu_p[0] = 1; lu_p[1] = 3;
    cmax[0] = 65535; cmax[1] = 15;
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mem_wait();
    test_branch_lu();
    test_lu3(1'b0);
    test_lu3(1'b1);
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
